// File: rtl/frame_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_pkg
// Description : Shared constants and types for the frame buffer memory-side
//               arbiter: request polarities, arbiter states, grant types.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buf_pkg;

  // Active-low request levels
  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;

  // Active-high command / strobe levels
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  // Arbiter states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_CMD = 2'd1,
    RD_CMD = 2'd2
  } arb_state_t;

  // Which request type received the most recent grant
  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_t;

endpackage : frame_buf_pkg
`default_nettype wire

// File: rtl/frame_buf_mem_arb_rd_pend_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rd_pend_cnt
// Description : Outstanding-read counter. Counts reads accepted by memory
//               minus read data returned; never wraps below zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_pend_cnt #(
  parameter int MAX_RD_PEND = 8,
  parameter int CNT_W       = $clog2(MAX_RD_PEND + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_RD_PEND);

  logic [CNT_W-1:0] r_cnt;

  assign pend_cnt = r_cnt;
  assign full     = (r_cnt == c_max_cnt);

  // Simultaneous inc/dec cancel; stray decrements at zero are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (inc && !dec && !full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule : rd_pend_cnt
`default_nettype wire

// File: rtl/frame_buf_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_mem_arb
// Description : Merges the frame buffer's active-low write and read requests
//               onto one Avalon-MM master, returns per-beat accept strobes,
//               registers read data and caps outstanding reads.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_mem_arb
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 29,
  parameter int MAX_RD_PEND = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_rdy,
  output logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [DATA_WIDTH-1:0] avl_wdata,
  output logic                  avl_write,
  output logic                  avl_read,
  input  logic                  avl_waitrequest,
  input  logic [DATA_WIDTH-1:0] avl_rdata,
  input  logic                  avl_readdatavalid
);

  localparam int c_cnt_w = $clog2(MAX_RD_PEND + 1);

  arb_state_t         r_state;
  grant_t             r_last_grant;
  logic [c_cnt_w-1:0] w_pend_cnt;
  logic               w_pend_full;
  logic               w_wr_elig;
  logic               w_rd_elig;
  logic               w_grant_wr;
  logic               w_grant_rd;

  // A read is only eligible while there is room for one more outstanding.
  assign w_wr_elig  = (wr_en == ASSERT_L);
  assign w_rd_elig  = (rd_en == ASSERT_L) && !w_pend_full;

  // Round-robin on contention: the type not granted last time wins.
  assign w_grant_wr = w_wr_elig && (!w_rd_elig || (r_last_grant == READ));
  assign w_grant_rd = w_rd_elig && !w_grant_wr;

  // Accept strobes fire in the single cycle the memory takes the command.
  assign wr_rdy = (r_state == WR_CMD) && !avl_waitrequest;
  assign rd_rdy = (r_state == RD_CMD) && !avl_waitrequest;

  rd_pend_cnt #(
    .MAX_RD_PEND (MAX_RD_PEND),
    .CNT_W       (c_cnt_w)
  ) u_rd_pend_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (rd_rdy),
    .dec      (avl_readdatavalid),
    .pend_cnt (w_pend_cnt),
    .full     (w_pend_full)
  );

  // Arbiter FSM: latch one request in IDLE, hold it on the bus until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= READ;
      avl_write    <= DEASSERT_H;
      avl_read     <= DEASSERT_H;
      avl_addr     <= '0;
      avl_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            avl_addr     <= wr_addr;
            avl_wdata    <= wr_data;
            avl_write    <= ASSERT_H;
            r_last_grant <= WRITE;
            r_state      <= WR_CMD;
          end else if (w_grant_rd) begin
            avl_addr     <= rd_addr;
            avl_read     <= ASSERT_H;
            r_last_grant <= READ;
            r_state      <= RD_CMD;
          end
        end
        WR_CMD: begin
          if (!avl_waitrequest) begin
            avl_write <= DEASSERT_H;
            r_state   <= IDLE;
          end
        end
        RD_CMD: begin
          if (!avl_waitrequest) begin
            avl_read <= DEASSERT_H;
            r_state  <= IDLE;
          end
        end
        default: begin
          avl_write <= DEASSERT_H;
          avl_read  <= DEASSERT_H;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Read return path: one-cycle registered copy of the memory's read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data       <= '0;
      rd_data_valid <= DEASSERT_H;
    end else begin
      rd_data_valid <= avl_readdatavalid;
      if (avl_readdatavalid) begin
        rd_data <= avl_rdata;
      end
    end
  end

endmodule : frame_buf_mem_arb
`default_nettype wire

// File: tb/tb_frame_buf_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buf_mem_arb
// Description : Self-checking bench for frame_buf_mem_arb with a
//               transaction-level reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_mem_arb;

  localparam int DW   = 32;
  localparam int AW   = 29;
  localparam int MAXP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_rdy;
  logic          rd_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata;
  logic          avl_write;
  logic          avl_read;
  logic          avl_waitrequest;
  logic [DW-1:0] avl_rdata;
  logic          avl_readdatavalid;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  frame_buf_mem_arb #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MAX_RD_PEND (MAXP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .wr_rdy            (wr_rdy),
    .rd_rdy            (rd_rdy),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .avl_addr          (avl_addr),
    .avl_wdata         (avl_wdata),
    .avl_write         (avl_write),
    .avl_read          (avl_read),
    .avl_waitrequest   (avl_waitrequest),
    .avl_rdata         (avl_rdata),
    .avl_readdatavalid (avl_readdatavalid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_busy;     // a beat is on the bus waiting to be taken
  bit            m_is_rd;    // that beat is a read
  bit            m_pref_wr;  // next contested grant goes to write
  bit            m_ret_v;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_ret_d;
  int            m_out;      // reads taken by memory, data not yet back

  always @(posedge clk or negedge reset) begin
    bit acc_rd;
    bit want_w;
    bit want_r;
    int nxt;
    if (!reset) begin
      m_busy = 0; m_is_rd = 0; m_pref_wr = 1; m_ret_v = 0;
      m_addr = '0; m_wdata = '0; m_ret_d = '0; m_out = 0;
    end else begin
      acc_rd = m_busy && m_is_rd && !avl_waitrequest;
      want_w = !wr_en;
      want_r = !rd_en && (m_out < MAXP);
      if (m_busy) begin
        if (!avl_waitrequest) m_busy = 0;
      end else if (want_w && (!want_r || m_pref_wr)) begin
        m_busy = 1; m_is_rd = 0; m_addr = wr_addr; m_wdata = wr_data; m_pref_wr = 0;
      end else if (want_r) begin
        m_busy = 1; m_is_rd = 1; m_addr = rd_addr; m_pref_wr = 1;
      end
      nxt   = m_out + (acc_rd ? 1 : 0) - (avl_readdatavalid ? 1 : 0);
      m_out = (nxt < 0) ? 0 : nxt;
      m_ret_v = avl_readdatavalid;
      if (avl_readdatavalid) m_ret_d = avl_rdata;
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    bit ew;
    bit er;
    ew = m_busy && !m_is_rd;
    er = m_busy && m_is_rd;
    chk("avl_write",     avl_write,     ew);
    chk("avl_read",      avl_read,      er);
    chk("avl_addr",      avl_addr,      m_addr);
    chk("avl_wdata",     avl_wdata,     m_wdata);
    chk("wr_rdy",        wr_rdy,        ew && !avl_waitrequest);
    chk("rd_rdy",        rd_rdy,        er && !avl_waitrequest);
    chk("rdy_exclusive", wr_rdy & rd_rdy, 1'b0);
    chk("rd_data_valid", rd_data_valid, m_ret_v);
    chk("rd_data",       rd_data,       m_ret_d);
    chk("pend_cnt",      dut.w_pend_cnt, m_out);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    avl_waitrequest = 1'b0; avl_rdata = '0; avl_readdatavalid = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_avl_write", avl_write, 1'b0);
    chk("rst_avl_read",  avl_read,  1'b0);
    chk("rst_avl_addr",  avl_addr,  '0);
    chk("rst_rd_valid",  rd_data_valid, 1'b0);
    chk("rst_pend",      dut.w_pend_cnt, 0);
    reset = 1'b1;

    // Write-only, no stall: beat every two cycles
    step();
    wr_en = 1'b0; wr_addr = 29'd2; wr_data = 32'hA5A5A5A5;
    step(); #1;
    chk("t1_write_1",  avl_write, 1'b1);
    chk("t1_addr",     avl_addr,  29'd2);
    chk("t1_wdata",    avl_wdata, 32'hA5A5A5A5);
    chk("t1_wr_rdy",   wr_rdy,    1'b1);
    step(); #1;
    chk("t1_write_gap", avl_write, 1'b0);
    chk("t1_rdy_gap",   wr_rdy,    1'b0);
    step(); #1;
    chk("t1_write_2",  avl_write, 1'b1);
    wr_en = 1'b1;
    step(); step();

    // Write stalled three cycles, request withdrawn while stalled
    avl_waitrequest = 1'b1; wr_en = 1'b0; wr_addr = 29'd7; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b1; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_hold_write", avl_write, 1'b1);
      chk("t2_hold_addr",  avl_addr,  29'd7);
      chk("t2_hold_wdata", avl_wdata, 32'hDEADBEEF);
      chk("t2_no_rdy",     wr_rdy,    1'b0);
      step();
    end
    avl_waitrequest = 1'b0; #1;
    chk("t2_write_4", avl_write, 1'b1);
    chk("t2_addr_4",  avl_addr,  29'd7);
    chk("t2_rdy_4",   wr_rdy,    1'b1);
    step(); #1;
    chk("t2_write_done", avl_write, 1'b0);

    // Both requesting from reset: W, R, W, R
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 29'h33; wr_data = 32'h01020304; rd_addr = 29'h55;
    step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      chk("t3_grant_w", avl_write, 1'b1);
      chk("t3_grant_w_rd", avl_read, 1'b0);
      step();
      step(); #1;
      chk("t3_grant_r", avl_read, 1'b1);
      chk("t3_grant_r_addr", avl_addr, 29'h55);
      step();
    end
    wr_en = 1'b1; rd_en = 1'b1;
    step(); step();

    // Outstanding-read cap
    reset = 1'b0;
    step();
    reset = 1'b1; rd_en = 1'b0; rd_addr = 29'h100;
    for (int i = 0; i < MAXP; i++) begin
      step(); #1;
      chk("t4_rd_grant", avl_read, 1'b1);
      step();
    end
    rd_addr = 29'h1FF;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("t4_full_block", avl_read, 1'b0);
    end
    chk("t4_pend_full", dut.w_pend_cnt, MAXP);
    avl_readdatavalid = 1'b1; avl_rdata = 32'h12345678;
    step();
    avl_readdatavalid = 1'b0; #1;
    chk("t5_valid",      rd_data_valid, 1'b1);
    chk("t5_data",       rd_data,       32'h12345678);
    chk("t4_still_blk",  avl_read,      1'b0);
    step(); #1;
    chk("t4_ninth_read", avl_read,      1'b1);
    chk("t4_ninth_addr", avl_addr,      29'h1FF);
    chk("t5_valid_off",  rd_data_valid, 1'b0);
    chk("t5_data_hold",  rd_data,       32'h12345678);
    rd_en = 1'b1;
    step();
    // Drain eight reads plus one stray return at zero
    for (int i = 0; i < MAXP + 1; i++) begin
      avl_readdatavalid = 1'b1; avl_rdata = 32'hC0DE0000 + i;
      step();
    end
    avl_readdatavalid = 1'b0;
    step(); #1;
    chk("t4_drained", dut.w_pend_cnt, 0);

    // Reset during a stalled write
    wr_en = 1'b0; avl_waitrequest = 1'b1; wr_addr = 29'd9;
    step(); #1;
    chk("t6_write_up", avl_write, 1'b1);
    reset = 1'b0; #1;
    chk("t6_write_drop", avl_write, 1'b0);
    chk("t6_no_rdy",     wr_rdy,    1'b0);
    wr_en = 1'b1;
    step();
    avl_waitrequest = 1'b0; reset = 1'b1;
    step(); #1;
    chk("t6_pend_zero", dut.w_pend_cnt, 0);
    chk("t6_idle",      avl_write,      1'b0);
    avl_readdatavalid = 1'b1; avl_rdata = 32'hCAFEF00D;
    step();
    avl_readdatavalid = 1'b0; #1;
    chk("t6_fwd_valid", rd_data_valid, 1'b1);
    chk("t6_fwd_data",  rd_data,       32'hCAFEF00D);
    chk("t6_fwd_pend",  dut.w_pend_cnt, 0);
    step(); step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_frame_buf_mem_arb
`default_nettype wire

// File: doc/frame_buf_mem_arb.md
Name: frame_buf_mem_arb

Overview:
- Memory-side stage directly downstream of the frame buffer address generator.
- Merges the generator's active-low write and read requests into one Avalon-MM master port for the external memory controller.
- Returns the per-beat accept strobes (wr_rdy, rd_rdy) that the generator uses to advance its addresses.
- Registers returned read data toward the display path and caps the number of outstanding reads.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 29, word address width
MAX_RD_PEND, 8, max reads issued but not yet returned (>=1)

Ports:
clk  input  1  single clock for all logic
reset  input  1  asynchronous, active-low reset
wr_en  input  1  write request from frame buffer, active-low
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request from frame buffer, active-low
rd_addr  input  ADDR_WIDTH  read address
wr_rdy  output  1  write beat accepted this cycle, active-high
rd_rdy  output  1  read beat accepted this cycle, active-high
rd_data  output  DATA_WIDTH  registered read data
rd_data_valid  output  1  rd_data valid, one-cycle pulse
avl_addr  output  ADDR_WIDTH  Avalon address
avl_wdata  output  DATA_WIDTH  Avalon write data
avl_write  output  1  Avalon write command
avl_read  output  1  Avalon read command
avl_waitrequest  input  1  Avalon stall
avl_rdata  input  DATA_WIDTH  Avalon read data
avl_readdatavalid  input  1  Avalon read data strobe

Behaviour:
- Reset (reset==0, async): state=IDLE, avl_write=avl_read=0, avl_addr=0, avl_wdata=0, rd_data=0, rd_data_valid=0, pend_cnt=0, last_grant=READ (so the first contested grant goes to write).
- States: IDLE, WR_CMD, RD_CMD.
- Eligibility in IDLE:
  - A write is eligible when wr_en==0.
  - A read is eligible when rd_en==0 and pend_cnt<MAX_RD_PEND.
- IDLE grant rules:
  - Exactly one eligible: grant it.
  - Both eligible: grant the one not equal to last_grant (round-robin).
  - Grant write: avl_addr<=wr_addr, avl_wdata<=wr_data, avl_write<=1, last_grant<=WRITE, go WR_CMD.
  - Grant read: avl_addr<=rd_addr, avl_read<=1, last_grant<=READ, go RD_CMD.
  - Neither eligible: stay IDLE, commands low.
- WR_CMD:
  - Hold avl_addr, avl_wdata and avl_write stable while avl_waitrequest==1.
  - In the cycle avl_waitrequest==0: wr_rdy=1 (combinational: state==WR_CMD & ~avl_waitrequest). Next edge: avl_write<=0, go IDLE.
- RD_CMD: same as WR_CMD, using rd_rdy and avl_read.
- A request latched in IDLE is always completed, even if wr_en/rd_en deasserts while stalled. The command is never withdrawn.
- wr_rdy and rd_rdy are never high together, and each is high at most one cycle per granted beat.
- Throughput: at most one beat per 2 cycles (IDLE + CMD) with no stall. Latency from request to first accept is 1 cycle.
- pend_cnt (width $clog2(MAX_RD_PEND+1)):
  - +1 on read accept (rd_rdy).
  - -1 on avl_readdatavalid.
  - Both in the same cycle: unchanged.
  - A decrement at 0 is ignored (stray data after reset). An increment at MAX_RD_PEND cannot occur by construction.
- Read return: rd_data<=avl_rdata and rd_data_valid<=1 on the edge after avl_readdatavalid==1. Otherwise rd_data_valid<=0 and rd_data holds. Returned data is in issue order.
- Reset mid-operation: an in-flight command drops immediately. Read data arriving after reset is still forwarded, but pend_cnt stays at 0.

Decomposition:
- Shared package frame_buf_pkg:
  - ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H constants.
  - Arbiter state encoding (IDLE, WR_CMD, RD_CMD).
  - Grant-type constants (WRITE, READ).
- One sub-module: rd_pend_cnt, the saturating up/down outstanding-read counter. It outputs pend_cnt and full (pend_cnt==MAX_RD_PEND).

Test Plan:
- Write only, waitrequest=0, wr_en low with wr_addr=2, data=0xA5A5A5A5 -> avl_write high 1 cycle later with avl_addr=2. wr_rdy pulses that same cycle. Beats every 2 cycles.
- Write granted while waitrequest held high 3 cycles -> avl_write, avl_addr and avl_wdata stable 4 cycles. wr_rdy high only in the 4th cycle.
- wr_en and rd_en both low continuously from reset -> grant order W,R,W,R. wr_rdy and rd_rdy are never both high.
- 8 reads issued with readdatavalid held off -> 9th read not granted (avl_read stays low) until one readdatavalid arrives, then granted.
- avl_readdatavalid with avl_rdata=0x12345678 -> rd_data=0x12345678 and rd_data_valid=1 exactly one cycle later, for one cycle.
- Assert reset during WR_CMD with waitrequest=1 -> avl_write=0 immediately, no wr_rdy. After release, state is IDLE and pend_cnt=0.
